// File: rtl/reg_file_mp_if.sv
// Bus bundle between the decode/issue/write-back side and the multi-port
// register file. Port i (read) or j (write) occupies slice [i*W +: W] of
// each packed vector.
//
// Timing contract (no valid/ready back-pressure): the master drives every
// input each cycle. rd_* are combinational lookups answered in the same
// cycle. wr_* and iss_* are sampled on the rising clock edge, and an
// enable of 0 makes the matching address/data don't-care.
interface reg_file_mp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32,
    parameter int ADDR_W     = $clog2(DEPTH),
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 1
);
    logic [NUM_RD-1:0]            rd_en;
    logic [NUM_RD*ADDR_W-1:0]     rd_addr;
    logic [NUM_RD*DATA_WIDTH-1:0] rd_data;
    logic [NUM_RD-1:0]            rd_busy;
    logic [NUM_WR-1:0]            wr_en;
    logic [NUM_WR*ADDR_W-1:0]     wr_addr;
    logic [NUM_WR*DATA_WIDTH-1:0] wr_data;
    logic                         iss_en;
    logic [ADDR_W-1:0]            iss_addr;
    logic [DEPTH-1:0]             busy_vec;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        input  rd_data, rd_busy, busy_vec
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        output rd_data, rd_busy, busy_vec
    );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port register file with optional same-cycle write-to-read bypass
// and a per-register pending-write scoreboard for RAW hazard detection.
// Register 0 is hard-wired to zero and is never marked busy.
module reg_file_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32,
    parameter int ADDR_W     = $clog2(DEPTH),
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 1,
    parameter bit BYPASS     = 1'b1
) (
    input logic          clk,
    input logic          rst_n,
    reg_file_mp_if.slave bus
);

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]      busy_q;
    logic [DEPTH-1:0]      busy_d;

    // Next array and scoreboard state: later write ports override earlier
    // ones, and an issue sets busy after all write-back clears.
    always_comb begin : next_state
        logic [ADDR_W-1:0] wa;
        wa     = '0;
        regs_d = regs_q;
        busy_d = busy_q;
        for (int j = 0; j < NUM_WR; j++) begin
            wa = bus.wr_addr[j*ADDR_W +: ADDR_W];
            if (bus.wr_en[j] && (wa != '0)) begin
                regs_d[wa] = bus.wr_data[j*DATA_WIDTH +: DATA_WIDTH];
                busy_d[wa] = 1'b0;
            end
        end
        if (bus.iss_en && (bus.iss_addr != '0)) begin
            busy_d[bus.iss_addr] = 1'b1;
        end
    end

    // Array and scoreboard registers; register 0 is never written so it
    // keeps its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                regs_q[k] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    // Combinational read ports. The bypass path is gated by rst_n so that
    // a write presented during reset cannot leak onto rd_data.
    always_comb begin : read_path
        logic [ADDR_W-1:0] ra;
        ra          = '0;
        bus.rd_data = '0;
        bus.rd_busy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            ra = bus.rd_addr[i*ADDR_W +: ADDR_W];
            if (bus.rd_en[i] && (ra != '0)) begin
                bus.rd_data[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[ra];
                bus.rd_busy[i] = busy_q[ra];
                if (BYPASS && rst_n) begin
                    for (int j = 0; j < NUM_WR; j++) begin
                        if (bus.wr_en[j] && (bus.wr_addr[j*ADDR_W +: ADDR_W] == ra)) begin
                            bus.rd_data[i*DATA_WIDTH +: DATA_WIDTH] =
                                bus.wr_data[j*DATA_WIDTH +: DATA_WIDTH];
                            bus.rd_busy[i] = bus.iss_en && (bus.iss_addr == ra);
                        end
                    end
                end
            end
        end
    end

    // Full scoreboard exported for the stall unit and debug.
    assign bus.busy_vec = busy_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: dut_a is NUM_WR=2 with bypass, dut_b is NUM_WR=1
// without bypass. Both share clock and reset.
module tb_reg_file_mp;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    reg_file_mp_if #(.DATA_WIDTH(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(2)) bus_a ();
    reg_file_mp_if #(.DATA_WIDTH(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(1)) bus_b ();

    reg_file_mp #(.DATA_WIDTH(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a)
    );
    reg_file_mp #(.DATA_WIDTH(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(1), .BYPASS(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b)
    );

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus_a.rd_en = '0; bus_a.rd_addr = 'x; bus_a.wr_en = '0; bus_a.wr_addr = 'x;
        bus_a.wr_data = 'x; bus_a.iss_en = 1'b0; bus_a.iss_addr = 'x;
        bus_b.rd_en = '0; bus_b.rd_addr = 'x; bus_b.wr_en = '0; bus_b.wr_addr = 'x;
        bus_b.wr_data = 'x; bus_b.iss_en = 1'b0; bus_b.iss_addr = 'x;
    endtask

    task automatic set_rd(input int p, input logic [4:0] a);
        bus_a.rd_en[p] = 1'b1; bus_a.rd_addr[p*5 +: 5] = a;
        bus_b.rd_en[p] = 1'b1; bus_b.rd_addr[p*5 +: 5] = a;
    endtask

    task automatic set_wr_a(input int p, input logic [4:0] a, input logic [31:0] d);
        bus_a.wr_en[p] = 1'b1; bus_a.wr_addr[p*5 +: 5] = a; bus_a.wr_data[p*32 +: 32] = d;
    endtask

    task automatic set_wr_b(input logic [4:0] a, input logic [31:0] d);
        bus_b.wr_en[0] = 1'b1; bus_b.wr_addr = a; bus_b.wr_data = d;
    endtask

    task automatic set_iss(input logic [4:0] a);
        bus_a.iss_en = 1'b1; bus_a.iss_addr = a;
        bus_b.iss_en = 1'b1; bus_b.iss_addr = a;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        // Held in reset from time 0, with a write, issue and read of r5 presented.
        idle(); set_rd(0, 5'd5); set_wr_a(0, 5'd5, 32'hCAFE0001); set_iss(5'd5);
        #1;
        if (bus_a.rd_data !== 64'h0) begin errors++; $display("FAIL reset_rd_data: got %h want 0", bus_a.rd_data); end
        checks++;
        if (bus_a.busy_vec !== 32'h0 || bus_a.rd_busy !== 2'b00) begin errors++; $display("FAIL reset_busy: got %h/%b want 0", bus_a.busy_vec, bus_a.rd_busy); end
        checks++;
        tick(); tick();
        #2 rst_n = 1'b1;
        idle(); set_rd(0, 5'd5);
        #1;
        if (bus_a.rd_data[31:0] !== 32'h0 || bus_a.busy_vec !== 32'h0) begin errors++; $display("FAIL reset_drop_write: got %h/%h want 0/0", bus_a.rd_data[31:0], bus_a.busy_vec); end
        checks++;
        // Write DEADBEEF to r5, then pulse reset mid-cycle.
        tick(); idle(); set_wr_a(0, 5'd5, 32'hDEADBEEF); set_iss(5'd6);
        tick(); idle(); set_rd(0, 5'd5);
        #1;
        if (bus_a.rd_data[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL reset_prewrite: got %h want deadbeef", bus_a.rd_data[31:0]); end
        checks++;
        set_wr_a(1, 5'd5, 32'h11111111);
        #2 rst_n = 1'b0;
        #1;
        if (bus_a.rd_data[31:0] !== 32'h0 || bus_a.busy_vec !== 32'h0) begin errors++; $display("FAIL reset_async: got %h/%h want 0/0", bus_a.rd_data[31:0], bus_a.busy_vec); end
        checks++;
        tick();
        #2 rst_n = 1'b1;
        idle(); set_rd(0, 5'd5);
        #1;
        if (bus_a.rd_data[31:0] !== 32'h0) begin errors++; $display("FAIL reset_async_drop: got %h want 0", bus_a.rd_data[31:0]); end
        checks++;
    endtask

    task automatic test_r0();
        tick(); idle();
        set_wr_a(0, 5'd0, 32'hFFFFFFFF); set_wr_b(5'd0, 32'hFFFFFFFF); set_iss(5'd0);
        set_rd(0, 5'd0);
        #1;
        if (bus_a.rd_data !== 64'h0 || bus_a.rd_busy !== 2'b00) begin errors++; $display("FAIL r0_same_cycle: got %h/%b want 0/00", bus_a.rd_data, bus_a.rd_busy); end
        checks++;
        tick(); idle(); set_rd(0, 5'd0);
        #1;
        if (bus_a.rd_data[31:0] !== 32'h0 || bus_b.rd_data[31:0] !== 32'h0) begin errors++; $display("FAIL r0_next_cycle: got %h/%h want 0/0", bus_a.rd_data[31:0], bus_b.rd_data[31:0]); end
        checks++;
        if (bus_a.busy_vec !== 32'h0 || bus_b.busy_vec !== 32'h0) begin errors++; $display("FAIL r0_busy: got %h/%h want 0/0", bus_a.busy_vec, bus_b.busy_vec); end
        checks++;
    endtask

    task automatic test_bypass();
        tick(); idle(); set_wr_b(5'd7, 32'h0BADF00D); set_wr_a(0, 5'd4, 32'h44444444);
        tick(); idle();
        set_wr_a(0, 5'd7, 32'h12345678); set_wr_b(5'd7, 32'h12345678);
        set_rd(0, 5'd7); set_rd(1, 5'd4);
        #1;
        if (bus_a.rd_data[31:0] !== 32'h12345678) begin errors++; $display("FAIL bypass_on: got %h want 12345678", bus_a.rd_data[31:0]); end
        checks++;
        if (bus_a.rd_data[63:32] !== 32'h44444444) begin errors++; $display("FAIL bypass_other_port: got %h want 44444444", bus_a.rd_data[63:32]); end
        checks++;
        if (bus_b.rd_data[31:0] !== 32'h0BADF00D) begin errors++; $display("FAIL bypass_off_old: got %h want 0badf00d", bus_b.rd_data[31:0]); end
        checks++;
        tick(); idle(); set_rd(0, 5'd7);
        #1;
        if (bus_b.rd_data[31:0] !== 32'h12345678) begin errors++; $display("FAIL bypass_off_new: got %h want 12345678", bus_b.rd_data[31:0]); end
        checks++;
    endtask

    task automatic test_collision();
        tick(); idle();
        set_wr_a(0, 5'd3, 32'h1); set_wr_a(1, 5'd3, 32'h2); set_rd(1, 5'd3);
        #1;
        if (bus_a.rd_data[63:32] !== 32'h2) begin errors++; $display("FAIL collision_bypass: got %h want 2", bus_a.rd_data[63:32]); end
        checks++;
        tick(); idle(); set_rd(1, 5'd3);
        #1;
        if (bus_a.rd_data[63:32] !== 32'h2) begin errors++; $display("FAIL collision_commit: got %h want 2", bus_a.rd_data[63:32]); end
        checks++;
    endtask

    task automatic test_scoreboard();
        tick(); idle(); set_iss(5'd9);
        tick(); idle(); set_rd(1, 5'd9);
        #1;
        if (bus_a.busy_vec !== 32'h200 || bus_b.busy_vec !== 32'h200) begin errors++; $display("FAIL sb_set: got %h/%h want 200", bus_a.busy_vec, bus_b.busy_vec); end
        checks++;
        if (bus_a.rd_busy[1] !== 1'b1 || bus_b.rd_busy[1] !== 1'b1) begin errors++; $display("FAIL sb_rd_busy: got %b/%b want 1/1", bus_a.rd_busy[1], bus_b.rd_busy[1]); end
        checks++;
        tick(); idle(); set_rd(1, 5'd9);
        tick(); idle(); set_rd(1, 5'd9);
        set_wr_a(0, 5'd9, 32'h99); set_wr_b(5'd9, 32'h99);
        #1;
        if (bus_a.rd_busy[1] !== 1'b0 || bus_a.rd_data[63:32] !== 32'h99) begin errors++; $display("FAIL sb_bypass_clear: got %b/%h want 0/99", bus_a.rd_busy[1], bus_a.rd_data[63:32]); end
        checks++;
        if (bus_b.rd_busy[1] !== 1'b1 || bus_b.rd_data[63:32] !== 32'h0) begin errors++; $display("FAIL sb_nobypass_busy: got %b/%h want 1/0", bus_b.rd_busy[1], bus_b.rd_data[63:32]); end
        checks++;
        tick(); idle(); set_rd(1, 5'd9);
        #1;
        if (bus_a.busy_vec !== 32'h0 || bus_b.busy_vec !== 32'h0) begin errors++; $display("FAIL sb_clear: got %h/%h want 0", bus_a.busy_vec, bus_b.busy_vec); end
        checks++;
        if (bus_b.rd_data[63:32] !== 32'h99 || bus_b.rd_busy[1] !== 1'b0) begin errors++; $display("FAIL sb_nobypass_data: got %h/%b want 99/0", bus_b.rd_data[63:32], bus_b.rd_busy[1]); end
        checks++;
    endtask

    task automatic test_iss_and_write();
        tick(); idle(); set_iss(5'd9);
        set_wr_a(1, 5'd9, 32'h55); set_wr_b(5'd9, 32'h55); set_rd(0, 5'd9);
        #1;
        if (bus_a.rd_busy[0] !== 1'b1 || bus_a.rd_data[31:0] !== 32'h55) begin errors++; $display("FAIL iw_same_cycle: got %b/%h want 1/55", bus_a.rd_busy[0], bus_a.rd_data[31:0]); end
        checks++;
        tick(); idle(); set_rd(0, 5'd9);
        #1;
        if (bus_a.busy_vec !== 32'h200 || bus_b.busy_vec !== 32'h200) begin errors++; $display("FAIL iw_busy: got %h/%h want 200", bus_a.busy_vec, bus_b.busy_vec); end
        checks++;
        if (bus_a.rd_data[31:0] !== 32'h55 || bus_b.rd_data[31:0] !== 32'h55) begin errors++; $display("FAIL iw_data: got %h/%h want 55", bus_a.rd_data[31:0], bus_b.rd_data[31:0]); end
        checks++;
        set_wr_a(0, 5'd9, 32'h0); set_wr_b(5'd9, 32'h0);
        tick(); idle();
    endtask

    // Random traffic on dut_a against a reference model of the array and
    // scoreboard; expectations queue up when stimulus is driven.
    task automatic test_back_to_back();
        logic [31:0] mem_m [32];
        logic [31:0] busy_m;
        logic [1:0]  we;
        logic [4:0]  wa [2];
        logic [31:0] wd [2];
        logic        ie;
        logic [4:0]  ia;
        logic [1:0]  re;
        logic [4:0]  ra [2];
        logic [31:0] d;
        logic [31:0] got;
        logic [31:0] exp;
        logic        b;
        idle(); rst_n = 1'b0;
        tick(); rst_n = 1'b1;
        for (int k = 0; k < 32; k++) mem_m[k] = 32'h0;
        busy_m = 32'h0;
        for (int n = 0; n < 300; n++) begin
            idle();
            we = 2'($urandom_range(0, 3));
            ie = 1'($urandom_range(0, 1));
            ia = 5'($urandom_range(0, 7));
            re = 2'($urandom_range(0, 3));
            for (int j = 0; j < 2; j++) begin
                wa[j] = 5'($urandom_range(0, 7));
                wd[j] = $urandom();
                if (we[j]) set_wr_a(j, wa[j], wd[j]);
                ra[j] = 5'($urandom_range(0, 7));
                if (re[j]) set_rd(j, ra[j]);
            end
            if (ie) set_iss(ia);
            for (int i = 0; i < 2; i++) begin
                d = 32'h0; b = 1'b0;
                if (re[i] && ra[i] != 5'd0) begin
                    d = mem_m[ra[i]]; b = busy_m[ra[i]];
                    for (int j = 0; j < 2; j++) begin
                        if (we[j] && wa[j] == ra[i]) begin
                            d = wd[j]; b = ie && (ia == ra[i]);
                        end
                    end
                end
                exp_q.push_back(d);
                exp_q.push_back({31'b0, b});
            end
            exp_q.push_back(busy_m);
            #1;
            for (int i = 0; i < 2; i++) begin
                got = bus_a.rd_data[i*32 +: 32]; exp = exp_q.pop_front();
                if (got !== exp) begin errors++; $display("FAIL rand_rd_data[%0d] cyc %0d: got %h want %h", i, n, got, exp); end
                checks++;
                got = {31'b0, bus_a.rd_busy[i]}; exp = exp_q.pop_front();
                if (got !== exp) begin errors++; $display("FAIL rand_rd_busy[%0d] cyc %0d: got %0d want %0d", i, n, got, exp); end
                checks++;
            end
            got = bus_a.busy_vec; exp = exp_q.pop_front();
            if (got !== exp) begin errors++; $display("FAIL rand_busy_vec cyc %0d: got %h want %h", n, got, exp); end
            checks++;
            tick();
            for (int j = 0; j < 2; j++) begin
                if (we[j] && wa[j] != 5'd0) begin
                    mem_m[wa[j]] = wd[j]; busy_m[wa[j]] = 1'b0;
                end
            end
            if (ie && ia != 5'd0) busy_m[ia] = 1'b1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        test_reset();
        test_r0();
        test_bypass();
        test_collision();
        test_scoreboard();
        test_iss_and_write();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-port register file for the mips_core decode stage. It generalises the 2-read/1-write file to N read ports, M write ports and a configurable depth and width. It adds same-cycle write-to-read bypass and a per-register pending-write scoreboard, which lets decode detect RAW hazards without a separate hazard table. It sits between the decoder, issue logic and write-back stage(s).

Parameters:
DATA_WIDTH, 32, bits per register
DEPTH, 32, number of registers; power of two, at least 2
ADDR_W, $clog2(DEPTH), address width (derived; do not override)
NUM_RD, 2, read ports, 1..4
NUM_WR, 1, write ports, 1..2
BYPASS, 1, 1 = a same-cycle write is forwarded to matching reads; 0 = reads return pre-write array contents

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
rd_en  in  NUM_RD  per-port read enable (uses_rs / uses_rt)
rd_addr  in  NUM_RD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_WIDTH  read data, port i packed the same way
rd_busy  out  NUM_RD  port i's register has an outstanding producer
wr_en  in  NUM_WR  write enable per write-back port (uses_rw)
wr_addr  in  NUM_WR*ADDR_W  write addresses
wr_data  in  NUM_WR*DATA_WIDTH  write data
iss_en  in  1  an instruction with a destination issues this cycle
iss_addr  in  ADDR_W  destination register of the issuing instruction
busy_vec  out  DEPTH  full scoreboard, for debug and the stall unit

Behaviour:
- Reset (rst_n low, asynchronous): all registers clear to 0; all busy bits clear.
  - Outputs during reset: rd_data = 0 per port, rd_busy = 0, busy_vec = 0.
  - A write or issue in the reset cycle is dropped.
- Register 0:
  - Always reads 0.
  - Writes to it are ignored.
  - It is never marked busy, and iss_addr = 0 is ignored.
- Reads are combinational (0-cycle latency).
  - rd_en[i] = 0 → rd_data[i] = 0 and rd_busy[i] = 0.
  - rd_addr[i] = 0 → rd_data[i] = 0 and rd_busy[i] = 0.
- Writes commit on the rising clk edge when wr_en[j] = 1 and wr_addr[j] != 0. They are visible to plain reads from the next cycle.
- Write collision: if both ports write the same address in one cycle, port NUM_WR-1 wins.
- BYPASS = 1: if a read address matches an active write this cycle, rd_data returns that wr_data, using the same priority (highest-index port wins). rd_busy for that port is then 0, unless iss_en targets the same address this cycle.
- BYPASS = 0: reads return array contents; rd_busy reflects registered busy bits only.
- Scoreboard, updated per clock edge:
  - busy[a] is set when iss_en = 1 and iss_addr = a (a != 0).
  - busy[a] is cleared when any wr_en[j] = 1 with wr_addr[j] = a.
  - Set and clear of the same address in one cycle: set wins (a new producer supersedes the completing one).
  - Issuing to an already-busy register keeps it busy (no counting; in-order write-back assumed).
  - Without BYPASS, rd_busy[i] = busy[rd_addr[i]] (registered value).
- No internal FSM beyond the array plus the DEPTH-bit scoreboard. No back-pressure. All inputs are sampled every cycle.
- X on an unused port's address must not propagate when its enable is 0.

Test Plan:
- Reset with NUM_RD=2: write 0xDEADBEEF to r5, pulse rst_n low mid-cycle → r5 immediately reads 0; busy_vec = 0.
- Write to r0: wr_en=1, wr_addr=0, wr_data=0xFFFFFFFF → read r0 = 0 on the same and next cycles; busy_vec[0] stays 0.
- Bypass (BYPASS=1): write r7 = 0x12345678 while rd_addr[0] = 7 → rd_data[0] = 0x12345678 in the same cycle. Repeat with BYPASS=0 → old value in the write cycle, new value next cycle.
- Dual write collision (NUM_WR=2): port0 writes r3 = 0x1 and port1 writes r3 = 0x2 in the same cycle → r3 reads 0x2.
- Scoreboard:
  - Issue r9 at cycle t → busy_vec[9] = 1 from t+1; rd_busy = 1 for a port reading r9.
  - Write r9 at t+3 → busy clears at t+4; with BYPASS=1, rd_busy = 0 already in t+3.
- Simultaneous issue and write to r9 → busy_vec[9] remains 1 after the edge; r9 holds the written data.
